// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, per-bit tick count and serializer state encoding.
package uart_pkg;

    localparam int unsigned DBIT_DEF      = 8;
    localparam int unsigned SB_TICK_DEF   = 16;
    localparam int unsigned TICKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO; pointers carry one wrap bit so full/empty come from MSB comparison.
module uart_tx_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic          do_push;
    logic          do_pop;

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed 8N1 serializer paced by the 16x oversampling tick.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = DBIT_DEF,
    parameter int unsigned SB_TICK = SB_TICK_DEF,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic            clk,
    input  logic            uart_reset,
    input  logic            tick,
    input  logic            writeFlag,
    input  logic [DBIT-1:0] dataToSend,
    output logic            txFull,
    output logic            txEmpty,
    output logic            txBusy,
    output logic            uart_tx_done,
    output logic            tx
);

    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    tx_state_e       state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            pop;
    logic [DBIT-1:0] head;

    uart_tx_fifo #(
        .DW(DBIT),
        .AW(ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (uart_reset),
        .push_i  (writeFlag),
        .pop_i   (pop),
        .wdata_i (dataToSend),
        .rdata_o (head),
        .full_o  (txFull),
        .empty_o (txEmpty)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!txEmpty) begin
                    shift_d = head;
                    pop     = 1'b1;
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 5'(TICKS_PER_BIT - 1)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 5'(TICKS_PER_BIT - 1)) begin
                        s_d     = '0;
                        shift_d = shift_q >> 1;
                        if (n_q == NW'(DBIT - 1)) state_d = STOP;
                        else                      n_d     = n_q + NW'(1);
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 5'(SB_TICK - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next state so the line changes on the same edge as the state.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge uart_reset) begin
        if (uart_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign txBusy       = (state_q != IDLE);
    assign uart_tx_done = done_q;
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: line monitor plus table vectors and FIFO/reset corner sequences.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst, tick, wr;
    logic [7:0] din;
    logic       full, empty, busy, done, tx;
    logic       rst_b, wr_b;
    logic [7:0] din_b;
    logic       full_b, empty_b, busy_b, done_b, tx_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_buffered dut (
        .clk(clk), .uart_reset(rst), .tick(tick), .writeFlag(wr), .dataToSend(din),
        .txFull(full), .txEmpty(empty), .txBusy(busy), .uart_tx_done(done), .tx(tx)
    );

    uart_tx_buffered #(.SB_TICK(32)) dut_b (
        .clk(clk), .uart_reset(rst_b), .tick(tick), .writeFlag(wr_b), .dataToSend(din_b),
        .txFull(full_b), .txEmpty(empty_b), .txBusy(busy_b), .uart_tx_done(done_b), .tx(tx_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] bitrev(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return r;
    endfunction

    // Tick changes just after the rising edge, one pulse every 4 clk.
    initial begin
        int tc;
        tc   = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick = (tc == 3);
            tc   = (tc + 1) % 4;
        end
    end

    // Line monitor for the default build; frames stored in transmit order, first data bit at MSB.
    logic [7:0] rxq[$];
    int         gapq[$];
    int         starts   = 0;
    int         mon_cnt  = 0;
    bit         inframe  = 1'b0;

    initial begin
        int cyc, last_done;
        logic ptx, ptk;
        logic [7:0] sh;
        cyc = 0; last_done = -100; ptx = 1'b1; ptk = 1'b0; sh = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                inframe = 1'b0;
            end else if (inframe) begin
                if (ptk) begin
                    mon_cnt++;
                    if (mon_cnt == 8) chk("start_bit_low", tx, 0);
                    for (int i = 0; i < 8; i++)
                        if (mon_cnt == 16*(i+1)+8) sh[7-i] = tx;
                    if (mon_cnt == 152) chk("stop_bit_high", tx, 1);
                end
                if (done) begin
                    chk("frame_ticks", mon_cnt, 160);
                    rxq.push_back(sh);
                    inframe   = 1'b0;
                    last_done = cyc;
                end
            end else begin
                if (done) chk("spurious_done", done, 0);
                if (ptx && !tx) begin
                    inframe = 1'b1;
                    mon_cnt = 0;
                    starts++;
                    gapq.push_back(cyc - last_done);
                end
            end
            ptx = tx;
            ptk = tick;
        end
    end

    task automatic wait_rx(input int n, input int budget);
        int b;
        b = budget;
        while (rxq.size() < n && b > 0) begin
            @(negedge clk);
            b--;
        end
        chk("wait_rx_timeout", (rxq.size() >= n), 1);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;   // transmit order, first data bit at MSB
    } vec_t;

    vec_t vt[6];

    initial begin
        int base, gbase, st, n, cnt;
        logic ptk;
        logic [7:0] shb;

        vt[0] = '{8'hA5, 8'hA5};
        vt[1] = '{8'h55, 8'hAA};
        vt[2] = '{8'h12, 8'h48};
        vt[3] = '{8'h0B, 8'hD0};
        vt[4] = '{8'h00, 8'h00};
        vt[5] = '{8'hFF, 8'hFF};

        rst = 1'b1; rst_b = 1'b1; wr = 1'b0; wr_b = 1'b0; din = '0; din_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_b_tx", tx_b, 1);
        rst = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            base = rxq.size();
            wr = 1'b1; din = vt[v].din;
            @(negedge clk);
            wr = 1'b0;
            chk("vec_empty_after_push", empty, 0);
            chk("vec_tx_still_idle", tx, 1);
            @(negedge clk);
            chk("vec_tx_start", tx, 0);
            chk("vec_busy", busy, 1);
            chk("vec_empty_after_pop", empty, 1);
            wait_rx(base + 1, 800);
            @(negedge clk);
            chk("vec_data", rxq[base], vt[v].exp);
            chk("vec_busy_end", busy, 0);
        end

        // Three consecutive pushes: gapless frames in order.
        base = rxq.size(); gbase = gapq.size();
        wr = 1'b1;
        din = 8'h00; @(negedge clk);
        din = 8'hFF; @(negedge clk);
        din = 8'h3C; @(negedge clk);
        wr = 1'b0;
        wait_rx(base + 3, 2400);
        repeat (100) @(negedge clk);
        chk("b2b_0", rxq[base],   8'h00);
        chk("b2b_1", rxq[base+1], 8'hFF);
        chk("b2b_2", rxq[base+2], 8'h3C);
        chk("b2b_gap1", gapq[gbase+1], 1);
        chk("b2b_gap2", gapq[gbase+2], 1);
        chk("b2b_count", rxq.size(), base + 3);
        chk("b2b_empty", empty, 1);

        // 17 pushes fill the FIFO; overflow and full-with-pop pushes are dropped.
        base = rxq.size();
        wr = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            din = 8'(i);
            @(negedge clk);
        end
        chk("fill_full", full, 1);
        din = 8'h12;
        @(negedge clk);
        wr = 1'b0;
        chk("fill_full_after_drop", full, 1);
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("fill_first_done", done, 1);
        wr = 1'b1; din = 8'h99;
        @(negedge clk);
        wr = 1'b0;
        chk("full_pop_push_full", full, 0);
        chk("full_pop_push_empty", empty, 0);
        wr = 1'b1; din = 8'hC3;
        @(negedge clk);
        wr = 1'b0;
        chk("refill_full", full, 1);
        wait_rx(base + 18, 18*800);
        repeat (800) @(negedge clk);
        chk("fill_count", rxq.size(), base + 18);
        for (int i = 0; i < 17; i++)
            chk("fill_seq", rxq[base+i], bitrev(8'(i + 1)));
        chk("fill_last", rxq[base+17], bitrev(8'hC3));
        chk("fill_empty", empty, 1);

        // Reset in DATA bit 3 of 0x55 with 5 bytes queued.
        base = rxq.size(); st = starts;
        wr = 1'b1; din = 8'h55;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            din = 8'(i);
            @(negedge clk);
        end
        wr = 1'b0;
        n = 0;
        while (!(inframe && mon_cnt >= 68) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached", (inframe && mon_cnt >= 68 && mon_cnt < 80), 1);
        chk("rst_mid_tx_before", tx, 0);
        rst = 1'b1;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_empty", empty, 1);
        chk("rst_mid_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (1400) @(negedge clk);
        chk("rst_mid_no_frames", rxq.size(), base);
        chk("rst_mid_starts", starts, st + 1);
        chk("rst_mid_tx_idle", tx, 1);
        chk("rst_mid_empty_after", empty, 1);

        // SB_TICK=32 build: stop bit 32 ticks, frame 176 ticks.
        wr_b = 1'b1; din_b = 8'h81;
        @(negedge clk);
        wr_b = 1'b0;
        n = 0;
        while (tx_b !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b_fall", tx_b, 0);
        cnt = 0; ptk = tick; shb = '0; n = 0;
        while (done_b !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (ptk) begin
                cnt++;
                for (int i = 0; i < 8; i++)
                    if (cnt == 16*(i+1)+8) shb[7-i] = tx_b;
                if (cnt == 152 || cnt == 175) chk("b_stop_high", tx_b, 1);
            end
            ptk = tick;
        end
        chk("b_done_seen", done_b, 1);
        chk("b_frame_ticks", cnt, 176);
        chk("b_data", shb, 8'h81);
        @(negedge clk);
        chk("b_done_one_clk", done_b, 0);
        chk("b_busy_end", busy_b, 0);
        chk("b_empty_end", empty_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
